multipeak_detect: RTL and testbench

Parametrised successor to the single-channel FFT peak finder. It scans a shared FFT result RAM address space once per `start` and reads all channels in parallel, one address per cycle. It reports, per channel, the linear bin index and squared magnitude of the largest bin inside a programmable window, plus a threshold-qualified `found` flag. It sits between the FFT blocks (one result RAM per channel, shared read address) and direction/localisation logic.

---
 rtl/peak_pkg.sv | 27 ++
 rtl/mag_sq.sv | 36 +++
 rtl/multipeak_detect.sv | 156 +++++++++++++++
 tb/tb_multipeak_detect.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peak_pkg.sv
// Shared types and helpers for the multi-channel FFT peak finder.
package peak_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam int unsigned IDX_MAX = 32;

  function automatic int mag_width(input int dw);
    return 2 * dw;
  endfunction

  // Reverses the low w bits of a; callers size-cast the result to w bits.
  function automatic logic [IDX_MAX-1:0] bitrev(input logic [IDX_MAX-1:0] a, input int w);
    logic [IDX_MAX-1:0] v;
    logic [IDX_MAX-1:0] r;
    v = a;
    r = '0;
    for (int i = 0; i < IDX_MAX; i++) begin
      if (i < w) begin
        r = {r[IDX_MAX-2:0], v[0]};
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mag_sq.sv
// Two-stage squared magnitude: registers signed re/im, then registers re^2 + im^2.
module mag_sq
  import peak_pkg::*;
#(
  parameter int DW = 14
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [2*DW-1:0] iq,
  output logic [2*DW-1:0] mag
);

  localparam int MAGW = mag_width(DW);

  logic signed [DW-1:0]   re_q;
  logic signed [DW-1:0]   im_q;
  logic signed [MAGW-1:0] sq_re;
  logic signed [MAGW-1:0] sq_im;

  assign sq_re = MAGW'(re_q) * MAGW'(re_q);
  assign sq_im = MAGW'(im_q) * MAGW'(im_q);

  // NOTE: non-blocking assignments make re/im and the sum two genuine register stages.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      re_q <= '0;
      im_q <= '0;
      mag  <= '0;
    end else begin
      re_q <= $signed(iq[2*DW-1:DW]);
      im_q <= $signed(iq[DW-1:0]);
      mag  <= $unsigned(sq_re) + $unsigned(sq_im);
    end
  end

endmodule

// File: rtl/multipeak_detect.sv
// Scans a shared-address FFT result RAM once per start and reports, per channel,
// the in-window peak bin, its squared magnitude and a threshold-qualified flag.
module multipeak_detect
  import peak_pkg::*;
#(
  parameter int LOG2N   = 10,
  parameter int DW      = 14,
  parameter int NCH     = 4,
  parameter int RAM_LAT = 2,
  parameter int BITREV  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [LOG2N-1:0]      lo_bin,
  input  logic [LOG2N-1:0]      hi_bin,
  input  logic [2*DW-1:0]       thresh,
  input  logic [NCH*2*DW-1:0]   ramq,
  output logic [LOG2N-1:0]      ramaddr,
  output logic                  busy,
  output logic                  done,
  output logic [NCH*LOG2N-1:0]  maxbin,
  output logic [NCH*2*DW-1:0]   maxmag,
  output logic [NCH-1:0]        found
);

  localparam int MAGW = mag_width(DW);
  localparam int DLY  = RAM_LAT + 2;  // issue to squared-magnitude output
  localparam int CW   = $clog2(DLY + 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DLY);

  state_t           state;
  logic [CW-1:0]    drain_cnt;
  logic [LOG2N-1:0] lo_q;
  logic [LOG2N-1:0] hi_q;
  logic [MAGW-1:0]  thresh_q;
  logic             accept;

  logic [LOG2N-1:0] issue_idx;
  logic [DLY-1:0]   pipe_v;
  logic [LOG2N-1:0] pipe_idx [DLY];
  logic             tail_v;
  logic [LOG2N-1:0] tail_idx;
  logic             in_win;

  logic [MAGW-1:0]  mag     [NCH];
  logic [MAGW-1:0]  run_max [NCH];
  logic [LOG2N-1:0] run_bin [NCH];
  logic [NCH-1:0]   seen;

  assign accept    = (state == IDLE) && start;
  assign issue_idx = (BITREV != 0) ? LOG2N'(bitrev(IDX_MAX'(ramaddr), LOG2N)) : ramaddr;
  assign tail_v    = pipe_v[DLY-1];
  assign tail_idx  = pipe_idx[DLY-1];
  assign in_win    = (tail_idx >= lo_q) && (tail_idx <= hi_q);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    mag_sq #(.DW(DW)) u_mag (
      .clk     (clk),
      .reset_n (reset_n),
      .iq      (ramq[c*2*DW +: 2*DW]),
      .mag     (mag[c])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      drain_cnt <= '0;
      ramaddr   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      lo_q      <= '0;
      hi_q      <= '0;
      thresh_q  <= '0;
      maxbin    <= '0;
      maxmag    <= '0;
      found     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SCAN;
            ramaddr  <= '0;
            busy     <= 1'b1;
            lo_q     <= lo_bin;
            hi_q     <= hi_bin;
            thresh_q <= thresh;
          end
        end
        SCAN: begin
          if (&ramaddr) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end else begin
            ramaddr <= ramaddr + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state <= DONE;
            done  <= 1'b1;
            for (int c = 0; c < NCH; c++) begin
              maxbin[c*LOG2N +: LOG2N] <= run_bin[c];
              maxmag[c*MAGW +: MAGW]   <= run_max[c];
              found[c]                 <= seen[c] && (run_max[c] > thresh_q);
            end
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          busy    <= 1'b0;
          ramaddr <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Running per-channel maxima; strict > keeps the earliest-scanned bin on ties.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_v <= '0;
      seen   <= '0;
      for (int c = 0; c < NCH; c++) begin
        run_max[c] <= '0;
        run_bin[c] <= '0;
      end
    end else begin
      pipe_v <= {pipe_v[DLY-2:0], state == SCAN};
      for (int c = 0; c < NCH; c++) begin
        if (accept) begin
          seen[c]    <= 1'b0;
          run_max[c] <= '0;
          run_bin[c] <= '0;
        end else if (tail_v && in_win && (!seen[c] || (mag[c] > run_max[c]))) begin
          seen[c]    <= 1'b1;
          run_max[c] <= mag[c];
          run_bin[c] <= tail_idx;
        end
      end
    end
  end

  // NOTE: the index delay line has no reset; the valid bits alone decide whether a stage is used.
  always_ff @(posedge clk) begin
    pipe_idx[0] <= issue_idx;
    for (int i = 1; i < DLY; i++) begin
      pipe_idx[i] <= pipe_idx[i-1];
    end
  end

endmodule

// File: tb/tb_multipeak_detect.sv
// Directed bench: one full-size instance plus two small instances covering RAM latency and bit reversal.
module tb_multipeak_detect;

  localparam int LG_M  = 10;
  localparam int N_M   = 1024;
  localparam int NCH_M = 4;
  localparam int LAT_M = 2;
  localparam int DW    = 14;
  localparam int W     = 2 * DW;
  localparam int LG_S  = 4;
  localparam int N_S   = 16;
  localparam int NCH_S = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // full-size instance, BITREV=0 so scan order equals linear bin order
  logic                  start_m = 1'b0;
  logic [LG_M-1:0]       lo_m = '0, hi_m = '0;
  logic [W-1:0]          thr_m = '0;
  logic [NCH_M*W-1:0]    ramq_m;
  logic [LG_M-1:0]       ramaddr_m;
  logic                  busy_m, done_m;
  logic [NCH_M*LG_M-1:0] maxbin_m;
  logic [NCH_M*W-1:0]    maxmag_m;
  logic [NCH_M-1:0]      found_m;

  // small instances: a = RAM_LAT 1 / BITREV 1, b = RAM_LAT 3 / BITREV 0
  logic                  start_a = 1'b0, start_b = 1'b0;
  logic [LG_S-1:0]       lo_s = '0, hi_s = '0;
  logic [W-1:0]          thr_s = '0;
  logic [NCH_S*W-1:0]    ramq_a, ramq_b;
  logic [LG_S-1:0]       ramaddr_a, ramaddr_b;
  logic                  busy_a, busy_b, done_a, done_b;
  logic [NCH_S*LG_S-1:0] maxbin_a, maxbin_b;
  logic [NCH_S*W-1:0]    maxmag_a, maxmag_b;
  logic [NCH_S-1:0]      found_a, found_b;

  multipeak_detect #(.LOG2N(LG_M), .DW(DW), .NCH(NCH_M), .RAM_LAT(LAT_M), .BITREV(0)) dut_m (
    .clk(clk), .reset_n(reset_n), .start(start_m), .lo_bin(lo_m), .hi_bin(hi_m),
    .thresh(thr_m), .ramq(ramq_m), .ramaddr(ramaddr_m), .busy(busy_m), .done(done_m),
    .maxbin(maxbin_m), .maxmag(maxmag_m), .found(found_m));

  multipeak_detect #(.LOG2N(LG_S), .DW(DW), .NCH(NCH_S), .RAM_LAT(1), .BITREV(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .lo_bin(lo_s), .hi_bin(hi_s),
    .thresh(thr_s), .ramq(ramq_a), .ramaddr(ramaddr_a), .busy(busy_a), .done(done_a),
    .maxbin(maxbin_a), .maxmag(maxmag_a), .found(found_a));

  multipeak_detect #(.LOG2N(LG_S), .DW(DW), .NCH(NCH_S), .RAM_LAT(3), .BITREV(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .lo_bin(lo_s), .hi_bin(hi_s),
    .thresh(thr_s), .ramq(ramq_b), .ramaddr(ramaddr_b), .busy(busy_b), .done(done_b),
    .maxbin(maxbin_b), .maxmag(maxmag_b), .found(found_b));

  // RAM models, indexed by physical address
  logic [W-1:0]    mem_m [NCH_M][N_M];
  logic [W-1:0]    mem_a [NCH_S][N_S];
  logic [W-1:0]    mem_b [NCH_S][N_S];
  logic [LG_M-1:0] ad_m [2];
  logic [LG_S-1:0] ad_a [1];
  logic [LG_S-1:0] ad_b [3];

  always @(posedge clk) begin
    ad_m[0] <= ramaddr_m;
    ad_m[1] <= ad_m[0];
    ad_a[0] <= ramaddr_a;
    ad_b[0] <= ramaddr_b;
    ad_b[1] <= ad_b[0];
    ad_b[2] <= ad_b[1];
  end

  always_comb begin
    ramq_m = '0;
    ramq_a = '0;
    ramq_b = '0;
    for (int c = 0; c < NCH_M; c++) ramq_m[c*W +: W] = mem_m[c][ad_m[1]];
    for (int c = 0; c < NCH_S; c++) begin
      ramq_a[c*W +: W] = mem_a[c][ad_a[0]];
      ramq_b[c*W +: W] = mem_b[c][ad_b[2]];
    end
  end

  typedef struct {
    int     ch;
    int     bin_a; int re_a; int im_a;
    int     bin_b; int re_b; int im_b;
    int     lo;    int hi;   longint thr;
    int     e_bin; longint e_mag; bit e_found;
  } vec_t;

  vec_t   vecs [7];
  int     checks = 0;
  int     errors = 0;
  int     exp_bin_m [NCH_M];
  longint exp_mag_m [NCH_M];
  bit     exp_found_m [NCH_M];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0] rev4(input logic [3:0] x);
    return {x[0], x[1], x[2], x[3]};
  endfunction

  task automatic clear_mem();
    for (int c = 0; c < NCH_M; c++)
      for (int b = 0; b < N_M; b++) mem_m[c][b] = '0;
    for (int c = 0; c < NCH_S; c++)
      for (int b = 0; b < N_S; b++) begin
        mem_a[c][b] = '0;
        mem_b[c][b] = '0;
      end
  endtask

  // tone channel gets the given values; silent channels hold the earliest in-window bin
  task automatic set_exp(input int tch, input int tb, input longint tm, input bit tf,
                         input int lo, input int hi);
    for (int c = 0; c < NCH_M; c++) begin
      if (c == tch) begin
        exp_bin_m[c] = tb; exp_mag_m[c] = tm; exp_found_m[c] = tf;
      end else begin
        exp_bin_m[c] = (lo <= hi) ? lo : 0; exp_mag_m[c] = 0; exp_found_m[c] = 1'b0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int c = 0; c < NCH_M; c++) begin
      check($sformatf("%s_ch%0d_bin", tag, c), 64'(maxbin_m[c*LG_M +: LG_M]), 64'(exp_bin_m[c]));
      check($sformatf("%s_ch%0d_mag", tag, c), 64'(maxmag_m[c*W +: W]), 64'(exp_mag_m[c]));
      check($sformatf("%s_ch%0d_found", tag, c), 64'(found_m[c]), 64'(exp_found_m[c]));
    end
  endtask

  task automatic scan_m(input logic [LG_M-1:0] lo, input logic [LG_M-1:0] hi,
                        input logic [W-1:0] thr, input bit poke);
    int lat;
    @(negedge clk);
    lo_m = lo; hi_m = hi; thr_m = thr; start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    check("busy_after_accept", 64'(busy_m), 64'd1);
    check("addr_after_accept", 64'(ramaddr_m), 64'd0);
    lat = 0;
    while (done_m !== 1'b1 && lat < 4000) begin
      start_m = poke && (lat == 100);
      if (poke && lat == 100) begin
        lo_m = 10'd500; hi_m = 10'd510; thr_m = '1;
      end
      if (poke && lat == 300) check_outputs("hold_mid_scan");
      @(negedge clk);
      lat++;
    end
    check("done_latency", 64'(lat), 64'(N_M + LAT_M + 3));
    start_m = 1'b1;  // a start during the done cycle must be ignored
    @(negedge clk);
    start_m = 1'b0;
    check("done_single_pulse", 64'(done_m), 64'd0);
    check("idle_not_busy", 64'(busy_m), 64'd0);
    check("idle_addr_zero", 64'(ramaddr_m), 64'd0);
  endtask

  task automatic scan_s(input bit sel, input logic [LG_S-1:0] lo, input logic [LG_S-1:0] hi);
    int lat;
    @(negedge clk);
    lo_s = lo; hi_s = hi; thr_s = '0;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    lat = 0;
    while (((sel ? done_b : done_a) !== 1'b1) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check(sel ? "b_done_latency" : "a_done_latency", 64'(lat), sel ? 64'(N_S + 3 + 3) : 64'(N_S + 1 + 3));
    @(negedge clk);
  endtask

  task automatic check_s(input bit sel, input string tag, input int c,
                         input int eb, input longint em, input bit ef);
    logic [LG_S-1:0] b;
    logic [W-1:0]    m;
    logic            f;
    b = sel ? maxbin_b[c*LG_S +: LG_S] : maxbin_a[c*LG_S +: LG_S];
    m = sel ? maxmag_b[c*W +: W] : maxmag_a[c*W +: W];
    f = sel ? found_b[c] : found_a[c];
    check($sformatf("%s_ch%0d_bin", tag, c), 64'(b), 64'(eb));
    check($sformatf("%s_ch%0d_mag", tag, c), 64'(m), 64'(em));
    check($sformatf("%s_ch%0d_found", tag, c), 64'(f), 64'(ef));
  endtask

  initial begin
    int cnt;
    vecs[0] = '{0, 100, 1000, -500, -1, 0, 0, 0, 1023, 0, 100, 1250000, 1'b1};
    vecs[1] = '{1, 20, 1000, 0, 300, 600, -200, 31, 1023, 0, 300, 400000, 1'b1};
    vecs[2] = '{2, 50, -8192, -8192, 60, -8192, -8192, 0, 1023, 0, 50, 134217728, 1'b1};
    vecs[3] = '{3, 700, 1000, 0, -1, 0, 0, 0, 1023, 1048576, 700, 1000000, 1'b0};
    vecs[4] = '{0, 550, 1000, 0, -1, 0, 0, 600, 500, 0, 0, 0, 1'b0};
    vecs[5] = '{0, 40, 3, 4, 41, 100, 0, 40, 40, 24, 40, 25, 1'b1};
    vecs[6] = '{3, 1023, -1, -1, 999, 5000, 0, 1000, 1023, 1, 1023, 2, 1'b1};

    clear_mem();
    repeat (3) @(negedge clk);
    set_exp(-1, 0, 0, 1'b0, 1, 0);
    check("reset_busy", 64'(busy_m), 64'd0);
    check("reset_done", 64'(done_m), 64'd0);
    check("reset_addr", 64'(ramaddr_m), 64'd0);
    check_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      clear_mem();
      mem_m[vecs[i].ch][vecs[i].bin_a] = {DW'(vecs[i].re_a), DW'(vecs[i].im_a)};
      if (vecs[i].bin_b >= 0)
        mem_m[vecs[i].ch][vecs[i].bin_b] = {DW'(vecs[i].re_b), DW'(vecs[i].im_b)};
      scan_m(LG_M'(vecs[i].lo), LG_M'(vecs[i].hi), W'(vecs[i].thr), 1'b0);
      set_exp(vecs[i].ch, vecs[i].e_bin, vecs[i].e_mag, vecs[i].e_found, vecs[i].lo, vecs[i].hi);
      check_outputs($sformatf("vec%0d", i));
    end

    // outputs hold while idle and during the next scan; stray starts in SCAN are ignored
    clear_mem();
    repeat (50) @(negedge clk);
    check_outputs("hold_idle");
    mem_m[0][200] = {DW'(0), DW'(300)};
    scan_m(10'd0, 10'd1023, '0, 1'b1);
    set_exp(0, 200, 90000, 1'b1, 0, 1023);
    check_outputs("poke");

    // reset mid-scan, then a fresh scan sees only new data
    clear_mem();
    mem_m[1][900] = {DW'(2000), DW'(0)};
    @(negedge clk);
    lo_m = 10'd0; hi_m = 10'd1023; thr_m = '0; start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    cnt = 0;
    while (ramaddr_m !== 10'd400 && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    check("reach_addr400", 64'(ramaddr_m), 64'd400);
    reset_n = 1'b0;
    #1;
    set_exp(-1, 0, 0, 1'b0, 1, 0);
    check("rst_busy", 64'(busy_m), 64'd0);
    check("rst_addr", 64'(ramaddr_m), 64'd0);
    check_outputs("rst_low");
    repeat (3) @(negedge clk);
    check("rst_done", 64'(done_m), 64'd0);
    check_outputs("rst_held");
    reset_n = 1'b1;
    clear_mem();
    mem_m[2][10] = {DW'(7), DW'(-24)};
    @(negedge clk);
    scan_m(10'd0, 10'd1023, '0, 1'b0);
    set_exp(2, 10, 625, 1'b1, 0, 1023);
    check_outputs("post_reset");

    // small instances: latency 1 with bit-reversed storage, latency 3 linear
    clear_mem();
    mem_a[0][rev4(4'd3)] = {DW'(10), DW'(0)};
    mem_a[1][rev4(4'd1)] = {DW'(2), DW'(-3)};
    mem_a[1][rev4(4'd8)] = {DW'(2), DW'(-3)};
    mem_b[0][15] = {DW'(-128), DW'(127)};
    mem_b[1][1]  = {DW'(2), DW'(-3)};
    mem_b[1][8]  = {DW'(2), DW'(-3)};
    scan_s(1'b0, 4'd0, 4'd15);
    check_s(1'b0, "a_full", 0, 3, 100, 1'b1);
    check_s(1'b0, "a_full", 1, 8, 13, 1'b1);
    scan_s(1'b0, 4'd4, 4'd15);
    check_s(1'b0, "a_win", 0, 8, 0, 1'b0);
    check_s(1'b0, "a_win", 1, 8, 13, 1'b1);
    scan_s(1'b1, 4'd0, 4'd15);
    check_s(1'b1, "b_full", 0, 15, 32513, 1'b1);
    check_s(1'b1, "b_full", 1, 1, 13, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
